// File: rtl/fifo_asym_gearbox_if.sv
// fifo_asym_gearbox_if: write/read handshake, occupancy and status bundle for the width-converting FIFO
interface fifo_asym_gearbox_if #(
  parameter int WR_DATA_WIDTH = 64,
  parameter int RD_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH    = 4
);
  localparam int N     = WR_DATA_WIDTH < RD_DATA_WIDTH ? WR_DATA_WIDTH : RD_DATA_WIDTH;
  localparam int RATIO = (WR_DATA_WIDTH > RD_DATA_WIDTH ? WR_DATA_WIDTH : RD_DATA_WIDTH) / N;
  localparam int CAP   = RATIO << ADDR_WIDTH;
  localparam int CW    = $clog2(CAP) + 1;
  logic                     flush;
  logic                     s_write_req;
  logic [WR_DATA_WIDTH-1:0] s_write_data;
  logic                     s_write_ready;
  logic                     s_read_req;
  logic                     s_read_ready;
  logic [RD_DATA_WIDTH-1:0] s_read_data;
  logic                     s_read_valid;
  logic [CW-1:0]            fill_count;
  logic                     almost_full;
  logic                     almost_empty;
  logic                     overflow;
  logic                     underflow;
  modport master (
    output flush, s_write_req, s_write_data, s_read_req,
    input  s_write_ready, s_read_ready, s_read_data, s_read_valid,
           fill_count, almost_full, almost_empty, overflow, underflow
  );
  modport slave (
    input  flush, s_write_req, s_write_data, s_read_req,
    output s_write_ready, s_read_ready, s_read_data, s_read_valid,
           fill_count, almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/fifo_asym_gearbox.sv
// fifo_asym_gearbox: width-converting FIFO storing narrow lanes, with occupancy, thresholds, flush and sticky error flags
module fifo_asym_gearbox #(
  parameter int WR_DATA_WIDTH = 64,
  parameter int RD_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH    = 4,
  parameter int AF_THRESH     = 2,
  parameter int AE_THRESH     = 2
) (
  input logic clk,
  input logic reset,
  fifo_asym_gearbox_if.slave bus
);
  localparam int N     = WR_DATA_WIDTH < RD_DATA_WIDTH ? WR_DATA_WIDTH : RD_DATA_WIDTH;
  localparam int RATIO = (WR_DATA_WIDTH > RD_DATA_WIDTH ? WR_DATA_WIDTH : RD_DATA_WIDTH) / N;
  localparam int CAP   = RATIO << ADDR_WIDTH;
  localparam int WU    = WR_DATA_WIDTH / N;
  localparam int RU    = RD_DATA_WIDTH / N;
  localparam int CW    = $clog2(CAP) + 1;
  localparam int PW    = $clog2(CAP);
  logic [N-1:0]             mem [CAP];
  logic [PW-1:0]            wr_ptr, rd_ptr;
  logic [CW-1:0]            fill;
  logic [RD_DATA_WIDTH-1:0] rd_word, rd_data;
  logic                     rd_valid, ovf, unf, wr_rdy, rd_rdy, wr_acc, rd_acc;
  assign wr_rdy = (CW'(CAP) - fill) >= CW'(WU);
  assign rd_rdy = fill >= CW'(RU);
  assign wr_acc = bus.s_write_req & wr_rdy & ~bus.flush;
  assign rd_acc = bus.s_read_req & rd_rdy & ~bus.flush;
  assign bus.s_write_ready = wr_rdy;
  assign bus.s_read_ready  = rd_rdy;
  assign bus.s_read_data   = rd_data;
  assign bus.s_read_valid  = rd_valid;
  assign bus.fill_count    = fill;
  assign bus.almost_full   = (CW'(CAP) - fill) <= CW'(AF_THRESH * RATIO);
  assign bus.almost_empty  = fill <= CW'(AE_THRESH * RATIO);
  assign bus.overflow      = ovf;
  assign bus.underflow     = unf;
  // gather the RU lanes at rd_ptr into one read word, oldest lane in the LSBs
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < RU; i++) rd_word[i*N +: N] = mem[rd_ptr + PW'(i)];
  end
  // scatter an accepted write word into WU consecutive lane slots
  always_ff @(posedge clk)
    if (wr_acc) for (int i = 0; i < WU; i++) mem[wr_ptr + PW'(i)] <= bus.s_write_data[i*N +: N];
  // pointers, occupancy, registered read port and sticky flags; flush keeps data and flags
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(WU);
      if (rd_acc) rd_ptr <= rd_ptr + PW'(RU);
      if (rd_acc) rd_data <= rd_word;
      rd_valid <= rd_acc;
      fill     <= fill + (wr_acc ? CW'(WU) : '0) - (rd_acc ? CW'(RU) : '0);
      if (bus.s_write_req & ~wr_rdy) ovf <= 1'b1;
      if (bus.s_read_req & ~rd_rdy) unf <= 1'b1;
    end
  end
endmodule
